p_div_pow2_pipe: RTL and testbench

Pipelined, multi-lane power-of-two divider with valid/ready handshake and a per-transaction shift amount and carry-up mode. It generalises the fixed-shift combinational divider. It is built for the perceptron datapath: it sits after accumulators to normalise INT/FXP sums before activation, with backpressure from the downstream stage. Each lane independently divides by 2^shift and rounds.

---
 rtl/p_div_pow2_pkg.sv | 33 +++
 rtl/p_div_pow2_if.sv | 31 +++
 rtl/p_div_pow2_lane.sv | 39 +++
 rtl/p_div_pow2_pipe.sv | 158 +++++++++++++++
 tb/tb_p_div_pow2_pipe.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/p_div_pow2_pkg.sv
// Shared types for the power-of-two divider: lane data configuration,
// carry-up modes and the shift-width helper.
package p_div_pow2_pkg;

  typedef enum logic [1:0] {
    DT_BOOL = 2'd0,
    DT_INT  = 2'd1,
    DT_FXP  = 2'd2,
    DT_FP   = 2'd3
  } dtype_e;

  typedef struct packed {
    dtype_e      dtype;
    logic [15:0] prec;
  } dconf_t;

  localparam dconf_t DEF_DCONF = '{dtype: DT_INT, prec: 16'd8};

  typedef enum logic [1:0] {
    CUP_FLOOR = 2'd0,
    CUP_HALF  = 2'd1,
    CUP_CEIL  = 2'd2
  } cup_mode_t;

  function automatic int calc_sw(input int max_shift);
    return $clog2(max_shift + 1);
  endfunction

endpackage

`ifndef DEF_DCONF
`define DEF_DCONF p_div_pow2_pkg::DEF_DCONF
`endif

// File: rtl/p_div_pow2_if.sv
// Valid/ready transaction bundle between a producer (master) and the divider (slave).
interface p_div_pow2_if
  import p_div_pow2_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int IW        = 8,
  parameter int OW        = 8,
  parameter int MAX_SHIFT = 8,
  parameter int SW        = calc_sw(MAX_SHIFT)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*IW-1:0]        in;
  logic [SW-1:0]              shift;
  logic [1:0]                 mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*OW-1:0]        out;
  logic [LANES*MAX_SHIFT-1:0] rem;
  logic [LANES-1:0]           ovf;

  modport master (
    output in_valid, in, shift, mode, out_ready,
    input  in_ready, out_valid, out, rem, ovf
  );

  modport slave (
    input  in_valid, in, shift, mode, out_ready,
    output in_ready, out_valid, out, rem, ovf
  );
endinterface

// File: rtl/p_div_pow2_lane.sv
// One lane of the divider: arithmetic shift, remainder extraction and carry-up decision.
// Expects shift_i already clamped to MAX_SHIFT.
module p_div_pow2_lane
  import p_div_pow2_pkg::*;
#(
  parameter int IW        = 8,
  parameter int MAX_SHIFT = 8,
  parameter int SW        = calc_sw(MAX_SHIFT)
) (
  input  logic [IW-1:0]        din_i,
  input  logic [SW-1:0]        shift_i,
  input  logic [1:0]           mode_i,
  output logic [IW:0]          q_o,
  output logic [MAX_SHIFT-1:0] r_o,
  output logic                 carry_o,
  output logic                 sign_o
);
  logic [MAX_SHIFT-1:0] r_s;
  logic [MAX_SHIFT-1:0] half_bit_s;

  // Shift/remainder/carry evaluation; mode 3 falls back to floor
  always_comb begin
    q_o        = $signed({din_i[IW-1], din_i}) >>> shift_i;
    r_s        = MAX_SHIFT'($signed(din_i)) & ~({MAX_SHIFT{1'b1}} << shift_i);
    half_bit_s = {{(MAX_SHIFT-1){1'b0}}, 1'b1} << (shift_i - SW'(1'b1));
    carry_o    = 1'b0;
    if (shift_i == '0) begin
      carry_o = 1'b0;
    end else begin
      case (mode_i)
        CUP_HALF: carry_o = |(r_s & half_bit_s);
        CUP_CEIL: carry_o = |r_s;
        default:  carry_o = 1'b0;
      endcase
    end
    r_o    = r_s;
    sign_o = din_i[IW-1];
  end
endmodule

// File: rtl/p_div_pow2_pipe.sv
// Two-stage multi-lane power-of-two divider with valid/ready flow control.
// Define P_DIV_POW2_SAT_EN to saturate narrowed results and report ovf per lane.
module p_div_pow2_pipe
  import p_div_pow2_pkg::*;
#(
  parameter int     LANES     = 4,
  parameter int     MAX_SHIFT = 8,
  parameter dconf_t I_CONF    = `DEF_DCONF,
  parameter dconf_t O_CONF    = `DEF_DCONF
) (
  input logic         clk,
  input logic         reset,
  p_div_pow2_if.slave bus
);
  localparam int IW      = int'(I_CONF.prec);
  localparam int OW      = int'(O_CONF.prec);
  localparam int SW      = calc_sw(MAX_SHIFT);
  localparam bit IS_BOOL = (I_CONF.dtype == DT_BOOL) || (O_CONF.dtype == DT_BOOL);

  if (I_CONF.dtype == DT_FP || O_CONF.dtype == DT_FP) begin : g_fp_unsupported
    $error("p_div_pow2_pipe: FP lane data is not supported");
  end

  logic                              adv1_s, adv2_s;
  logic [SW-1:0]                     shift_c_s;
  logic [LANES-1:0][IW:0]            q_s;
  logic [LANES-1:0][MAX_SHIFT-1:0]   r_s;
  logic [LANES-1:0]                  carry_s, sign_s;

  logic                              s1_valid_q;
  logic [LANES-1:0][IW:0]            s1_q_q;
  logic [LANES-1:0][MAX_SHIFT-1:0]   s1_r_q;
  logic [LANES-1:0]                  s1_carry_q, s1_sign_q;

  logic                              out_valid_q;
  logic [LANES-1:0][OW-1:0]          out_q, out_d;
  logic [LANES-1:0][MAX_SHIFT-1:0]   rem_q, rem_d;
  logic [LANES-1:0]                  ovf_q, ovf_d;

  assign adv2_s = !out_valid_q || bus.out_ready;
  assign adv1_s = !s1_valid_q || adv2_s;

  // Clamp the requested shift to the supported range
  always_comb begin
    if (bus.shift > SW'(MAX_SHIFT)) begin
      shift_c_s = SW'(MAX_SHIFT);
    end else begin
      shift_c_s = bus.shift;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [IW:0]          sum_s;
    logic [OW-1:0]        out_l_s;
    logic [MAX_SHIFT-1:0] rem_l_s;
    logic                 ovf_l_s;

    p_div_pow2_lane #(.IW(IW), .MAX_SHIFT(MAX_SHIFT), .SW(SW)) u_lane (
      .din_i   (bus.in[i*IW +: IW]),
      .shift_i (shift_c_s),
      .mode_i  (bus.mode),
      .q_o     (q_s[i]),
      .r_o     (r_s[i]),
      .carry_o (carry_s[i]),
      .sign_o  (sign_s[i])
    );

`ifdef P_DIV_POW2_SAT_EN
    localparam int WW = IW + OW + 2;
    localparam logic signed [WW-1:0] OMAX = (WW'(1'b1) << (OW - 1)) - WW'(1'b1);
    localparam logic signed [WW-1:0] OMIN = -(WW'(1'b1) << (OW - 1));
    localparam logic [OW-1:0] OMAX_O = OMAX[OW-1:0];
    localparam logic [OW-1:0] OMIN_O = OMIN[OW-1:0];
    logic signed [WW-1:0] wide_s;

    // Round, then clamp to the output range; direction follows the input sign
    always_comb begin
      sum_s  = s1_q_q[i] + {{IW{1'b0}}, s1_carry_q[i]};
      wide_s = WW'($signed(sum_s));
      if (wide_s > OMAX || wide_s < OMIN) begin
        out_l_s = s1_sign_q[i] ? OMIN_O : OMAX_O;
        ovf_l_s = 1'b1;
      end else begin
        out_l_s = OW'($signed(sum_s));
        ovf_l_s = 1'b0;
      end
      rem_l_s = s1_r_q[i];
      if (IS_BOOL) begin
        out_l_s = '0;
        ovf_l_s = 1'b0;
        rem_l_s = '0;
      end else begin
        rem_l_s = s1_r_q[i];
      end
    end
`else
    logic unused_sign_s;
    assign unused_sign_s = s1_sign_q[i];

    // Round, then wrap or sign-extend to the output width
    always_comb begin
      sum_s   = s1_q_q[i] + {{IW{1'b0}}, s1_carry_q[i]};
      out_l_s = OW'($signed(sum_s));
      ovf_l_s = 1'b0;
      rem_l_s = s1_r_q[i];
      if (IS_BOOL) begin
        out_l_s = '0;
        rem_l_s = '0;
      end else begin
        rem_l_s = s1_r_q[i];
      end
    end
`endif

    assign out_d[i] = out_l_s;
    assign rem_d[i] = rem_l_s;
    assign ovf_d[i] = ovf_l_s;
  end

  // Stage 1 captures shift results on the in handshake; stage 2 holds outputs while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_q_q      <= '0;
      s1_r_q      <= '0;
      s1_carry_q  <= '0;
      s1_sign_q   <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= '0;
    end else begin
      if (adv1_s) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_q_q     <= q_s;
          s1_r_q     <= r_s;
          s1_carry_q <= carry_s;
          s1_sign_q  <= sign_s;
        end
      end
      if (adv2_s) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_q <= out_d;
          rem_q <= rem_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.in_ready  = adv1_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.rem       = rem_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_p_div_pow2_pipe.sv
// Directed bench for p_div_pow2_pipe: INT8->INT8 four-lane unit plus an INT16->INT8 single-lane unit.
module tb_p_div_pow2_pipe;
  import p_div_pow2_pkg::*;

  localparam dconf_t C16 = '{dtype: DT_INT, prec: 16'd16};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  p_div_pow2_if #(.LANES(4), .IW(8),  .OW(8), .MAX_SHIFT(8), .SW(4)) bus8 ();
  p_div_pow2_if #(.LANES(1), .IW(16), .OW(8), .MAX_SHIFT(8), .SW(4)) bus16 ();

  p_div_pow2_pipe #(.LANES(4), .MAX_SHIFT(8)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );
  p_div_pow2_pipe #(.LANES(1), .MAX_SHIFT(8), .I_CONF(C16), .O_CONF(DEF_DCONF)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16)
  );

  typedef struct {
    logic [31:0] din;
    logic [3:0]  shift;
    logic [1:0]  mode;
    logic [31:0] exp_out;
    logic [31:0] exp_rem;
  } vec_t;

  typedef struct {
    logic [15:0] din;
    logic [1:0]  mode;
    logic [7:0]  exp_out;
    logic        exp_ovf;
  } vec16_t;

  vec_t   vecs   [10];
  vec16_t vecs16 [5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send8(input logic [31:0] din, input logic [3:0] sh, input logic [1:0] md);
    int n = 0;
    @(negedge clk);
    bus8.in = din; bus8.shift = sh; bus8.mode = md; bus8.in_valid = 1'b1;
    #1;
    while (!bus8.in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("send8_accept", {63'd0, bus8.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
  endtask

  // returns negedges waited until out_valid, or -1 on timeout
  task automatic wait_out8(output int lat);
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus8.out_valid) begin
        lat = n;
        return;
      end
    end
  endtask

  task automatic send16(input logic [15:0] din, input logic [1:0] md, output int lat);
    @(negedge clk);
    bus16.in = din; bus16.shift = 4'd1; bus16.mode = md; bus16.in_valid = 1'b1;
    @(posedge clk);
    #1 bus16.in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (bus16.out_valid) begin
        lat = n;
        return;
      end
    end
  endtask

  logic [31:0] bp_in  [5];
  logic [31:0] bp_exp [5];
  logic [31:0] tp_in  [4];
  logic [31:0] got [$];

  initial begin
    int lat;
    int sent;
    int cyc;
    int vcnt;
    bit fire;
    bit prev_stall;
    bit tp_block;
    logic [31:0] prev_out;

    vecs[0] = '{32'h000000F9, 4'd1,  2'd0, 32'h000000FC, 32'h00000001};
    vecs[1] = '{32'h000000F9, 4'd1,  2'd1, 32'h000000FD, 32'h00000001};
    vecs[2] = '{32'h000000F9, 4'd1,  2'd2, 32'h000000FD, 32'h00000001};
    vecs[3] = '{32'h7FF80E0D, 4'd2,  2'd1, 32'h20FE0403, 32'h03000201};
    vecs[4] = '{32'h00000080, 4'd0,  2'd2, 32'h00000080, 32'h00000000};
    vecs[5] = '{32'h00000080, 4'd15, 2'd0, 32'h000000FF, 32'h00000080};
    vecs[6] = '{32'h00000080, 4'd15, 2'd2, 32'h00000000, 32'h00000080};
    vecs[7] = '{32'h000000F9, 4'd1,  2'd3, 32'h000000FC, 32'h00000001};
    vecs[8] = '{32'h40C0807F, 4'd8,  2'd1, 32'h00000000, 32'h40C0807F};
    vecs[9] = '{32'hF708817F, 4'd3,  2'd2, 32'hFF01F110, 32'h07000107};

`ifdef P_DIV_POW2_SAT_EN
    vecs16[0] = '{16'd1000, 2'd0, 8'h7F, 1'b1};
    vecs16[1] = '{16'hFC18, 2'd0, 8'h80, 1'b1};
    vecs16[3] = '{16'h00FF, 2'd1, 8'h7F, 1'b1};
`else
    vecs16[0] = '{16'd1000, 2'd0, 8'hF4, 1'b0};
    vecs16[1] = '{16'hFC18, 2'd0, 8'h0C, 1'b0};
    vecs16[3] = '{16'h00FF, 2'd1, 8'h80, 1'b0};
`endif
    vecs16[2] = '{16'h00C8, 2'd0, 8'h64, 1'b0};
    vecs16[4] = '{16'hFF01, 2'd1, 8'h81, 1'b0};

    bp_in  = '{32'h02040608, 32'h0A0C0E10, 32'h12141618, 32'h1A1C1E20, 32'h22242628};
    bp_exp = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
    tp_in  = '{32'h80FF017F, 32'h11223344, 32'hF0E0D0C0, 32'h00000001};

    reset = 1'b1;
    bus8.in_valid = 1'b0; bus8.in = '0; bus8.shift = '0; bus8.mode = '0; bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in = '0; bus16.shift = '0; bus16.mode = '0; bus16.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    chk("rst_out", {32'd0, bus8.out}, 64'd0);
    chk("rst_rem", {32'd0, bus8.rem}, 64'd0);
    chk("rst_ovf", {60'd0, bus8.ovf}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, bus8.in_ready}, 64'd1);

    for (int i = 0; i < 10; i++) begin
      send8(vecs[i].din, vecs[i].shift, vecs[i].mode);
      wait_out8(lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd2);
      if (lat > 0) begin
        chk($sformatf("v%0d_out", i), {32'd0, bus8.out}, {32'd0, vecs[i].exp_out});
        chk($sformatf("v%0d_rem", i), {32'd0, bus8.rem}, {32'd0, vecs[i].exp_rem});
        chk($sformatf("v%0d_ovf", i), {60'd0, bus8.ovf}, 64'd0);
      end
    end

    for (int i = 0; i < 5; i++) begin
      send16(vecs16[i].din, vecs16[i].mode, lat);
      chk($sformatf("w%0d_latency", i), 64'(lat), 64'd2);
      if (lat > 0) begin
        chk($sformatf("w%0d_out", i), {56'd0, bus16.out}, {56'd0, vecs16[i].exp_out});
        chk($sformatf("w%0d_ovf", i), {63'd0, bus16.ovf}, {63'd0, vecs16[i].exp_ovf});
      end
    end

    // Backpressure: out_ready pattern 1,0,0 repeating
    @(negedge clk);
    bus8.shift = 4'd1; bus8.mode = 2'd0;
    got.delete(); sent = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (got.size() < 5 && cyc < 100) begin
      @(negedge clk);
      bus8.out_ready = (cyc % 3 == 0);
      bus8.in_valid  = (sent < 5);
      bus8.in        = bp_in[(sent < 5) ? sent : 4];
      #1;
      if (prev_stall) begin
        chk("bp_hold_valid", {63'd0, bus8.out_valid}, 64'd1);
        chk("bp_hold_out", {32'd0, bus8.out}, {32'd0, prev_out});
      end
      prev_stall = bus8.out_valid && !bus8.out_ready;
      prev_out   = bus8.out;
      if (bus8.out_valid && bus8.out_ready) got.push_back(bus8.out);
      fire = bus8.in_valid && bus8.in_ready;
      @(posedge clk);
      if (fire) sent++;
      cyc++;
    end
    #1 bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
    chk("bp_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("bp_order%0d", i), {32'd0, got[i]}, {32'd0, bp_exp[i]});

    // Full throughput: four back-to-back transactions, shift 0 returns the input
    repeat (3) @(posedge clk);
    bus8.shift = 4'd0; bus8.mode = 2'd0;
    got.delete(); sent = 0; cyc = 0; tp_block = 1'b0;
    while (got.size() < 4 && cyc < 50) begin
      @(negedge clk);
      bus8.in_valid = (sent < 4);
      bus8.in       = tp_in[(sent < 4) ? sent : 3];
      #1;
      if (bus8.out_valid) got.push_back(bus8.out);
      if (bus8.in_valid && !bus8.in_ready) tp_block = 1'b1;
      fire = bus8.in_valid && bus8.in_ready;
      @(posedge clk);
      if (fire) sent++;
      cyc++;
    end
    #1 bus8.in_valid = 1'b0;
    chk("tp_cycles", 64'(cyc), 64'd6);
    chk("tp_in_ready", {63'd0, tp_block}, 64'd0);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("tp_data%0d", i), {32'd0, got[i]}, {32'd0, tp_in[i]});

    // Reset with both stages full
    @(negedge clk);
    bus8.out_ready = 1'b0; bus8.shift = 4'd1; bus8.in = 32'h10101010; bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in = 32'h20202020;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    #1;
    chk("full_out_valid", {63'd0, bus8.out_valid}, 64'd1);
    chk("full_in_ready", {63'd0, bus8.in_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", {63'd0, bus8.out_valid}, 64'd0);
    chk("mid_rst_out", {32'd0, bus8.out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus8.out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, bus8.in_ready}, 64'd1);
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus8.out_valid) vcnt++;
    end
    chk("post_rst_no_stale", 64'(vcnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
